// File: rtl/mdu_hilo.sv
// HI/LO multiply-divide unit: pipelined-latency MULT/MULTU and a radix-2 iterative DIV/DIVU.
// Define MDU_DIV_EN to compile the divider in; without it DIV/DIVU complete at once and leave HI/LO as they were.
module mdu_hilo #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        hi_sel,
  output logic        busy,
  output logic        done,
  output logic [31:0] s_value
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  localparam logic [5:0] MUL_LAT_C = 6'(MUL_LAT);
  localparam logic [5:0] DIV_LAT_C = 6'd32;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sgn_q, sgn_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic [63:0] a_ext_s, b_ext_s, prod_s;

  assign a_ext_s = {{32{sgn_q & a_q[31]}}, a_q};
  assign b_ext_s = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod_s  = a_ext_s * b_ext_s;

`ifdef MDU_DIV_EN
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic        a_neg_s, b_neg_s, ge_s;
  logic [31:0] rem_lo_s, rem_nx_s, quo_nx_s;
  logic [32:0] diff_s;

  // Division runs on magnitudes; signs are restored on the completion edge.
  assign a_neg_s  = ~op[0] & a[31];
  assign b_neg_s  = ~op[0] & b[31];
  assign rem_lo_s = {rem_q[30:0], quo_q[31]};
  assign diff_s   = {rem_q[31], rem_lo_s} - {1'b0, dvs_q};
  assign ge_s     = ~diff_s[32];
  assign rem_nx_s = ge_s ? diff_s[31:0] : rem_lo_s;
  assign quo_nx_s = {quo_q[30:0], ge_s};
`endif

  // Next-state, datapath and result selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MDU_DIV_EN
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op[1] == 1'b0) begin
            state_d = S_MUL;
            busy_d  = 1'b1;
            cnt_d   = 6'd1;
            a_d     = a;
            b_d     = b;
            sgn_d   = ~op[0];
          end else begin
`ifdef MDU_DIV_EN
            state_d = S_DIV;
            busy_d  = 1'b1;
            cnt_d   = 6'd1;
            a_d     = a;
            b_d     = b;
            sgn_d   = ~op[0];
            rem_d   = 32'd0;
            quo_d   = a_neg_s ? (32'd0 - a) : a;
            dvs_d   = b_neg_s ? (32'd0 - b) : b;
            qneg_d  = a_neg_s ^ b_neg_s;
            rneg_d  = a_neg_s;
            dz_d    = (b == 32'd0);
`else
            done_d  = 1'b1;
`endif
          end
        end else if (mthi || mtlo) begin
          if (mthi) hi_d = a;
          else      hi_d = hi_q;
          if (mtlo) lo_d = a;
          else      lo_d = lo_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (cnt_q == MUL_LAT_C) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = prod_s[63:32];
          lo_d    = prod_s[31:0];
        end else begin
          cnt_d   = cnt_q + 6'd1;
        end
      end
      S_DIV: begin
`ifdef MDU_DIV_EN
        rem_d = rem_nx_s;
        quo_d = quo_nx_s;
        if (cnt_q == DIV_LAT_C) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (dz_q) begin
            hi_d = a_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rneg_q ? (32'd0 - rem_nx_s) : rem_nx_s;
            lo_d = qneg_q ? (32'd0 - quo_nx_s) : quo_nx_s;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
`else
        state_d = S_IDLE;
        busy_d  = 1'b0;
`endif
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MDU_DIV_EN
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MDU_DIV_EN
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign s_value = hi_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: stimulus pushes expected HI/LO, a monitor checks them on each done pulse.
module tb_mdu_hilo;
  localparam int LAT = 3;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0, hi_sel = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        busy, done;
  logic [31:0] s_value;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  mdu_hilo #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .hi_sel(hi_sel),
    .busy(busy), .done(done), .s_value(s_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_hilo(input string nm, input logic [31:0] eh, input logic [31:0] el);
    hi_sel = 1'b1; #1;
    chk({nm, "_hi"}, s_value, eh);
    hi_sel = 1'b0; #1;
    chk({nm, "_lo"}, s_value, el);
  endtask

  // Monitor: on every done pulse pop the oldest expectation and compare HI/LO.
  initial begin : monitor
    exp_t        e;
    logic        pd;
    logic [31:0] have;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        chk("done_not_consecutive", {31'd0, pd}, 32'd0);
        chk("busy_low_at_done", {31'd0, busy}, 32'd0);
        have = (sb.size() != 0) ? 32'd1 : 32'd0;
        chk("pending_on_done", have, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_hilo(e.name, e.hi, e.lo);
        end
      end
      pd = rst_n & done;
    end
  end

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el, input int elat,
                        input logic ebusy, input logic mv, input int disturb);
    exp_t e;
    int   n;
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1; mthi = mv; mtlo = mv;
    e.name = nm; e.hi = eh; e.lo = el;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b11; a = 32'hDEAD_BEEF; b = 32'h0000_0001;
    chk({nm, "_busy"}, {31'd0, busy}, {31'd0, ebusy});
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (disturb > 0 && n == disturb + 1) begin
        start = 1'b0; mthi = 1'b0;
      end
      if (disturb > 0 && n == disturb && !done) begin
        start = 1'b1; op = 2'b00; mthi = 1'b1; a = 32'd5;
      end
    end
    chk({nm, "_latency"}, 32'(n), 32'(elat));
    start = 1'b0; mthi = 1'b0;
    m_hi = eh; m_lo = el;
  endtask

  task automatic move(input string nm, input logic h, input logic l, input logic [31:0] v);
    @(negedge clk);
    mthi = h; mtlo = l; a = v;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0; a = 32'h0BAD_F00D;
    if (h) m_hi = v;
    if (l) m_lo = v;
    check_hilo(nm, m_hi, m_lo);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int rst_at;
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    check_hilo("reset", 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mult_m2x3",    2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, LAT, 1'b1, 1'b0, 0);
    run_op("multu_m2x3",   2'b01, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, LAT, 1'b1, 1'b0, 0);
    run_op("multu_max",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT, 1'b1, 1'b0, 0);
    run_op("mult_minmin",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, LAT, 1'b1, 1'b0, 0);
    run_op("mult_7xm5",    2'b00, 32'd7, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, LAT, 1'b1, 1'b0, 0);

    move("mthi", 1'b1, 1'b0, 32'd5);
    move("mtlo", 1'b0, 1'b1, 32'd9);
    move("mthilo", 1'b1, 1'b1, 32'h0000_0077);

    run_op("start_beats_move", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, LAT, 1'b1, 1'b1, 0);

`ifdef MDU_DIV_EN
    run_op("div_m7_2",     2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32, 1'b1, 1'b0, 0);
    run_op("divu_100_7",   2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 32, 1'b1, 1'b0, 0);
    run_op("divu_by0",     2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 32, 1'b1, 1'b0, 0);
    run_op("div_by0",      2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32, 1'b1, 1'b0, 0);
    run_op("div_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32, 1'b1, 1'b0, 0);
    run_op("div_7_m2",     2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 32, 1'b1, 1'b0, 0);
    run_op("divu_big",     2'b11, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999, 32, 1'b1, 1'b0, 0);
    run_op("div_disturbed", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32, 1'b1, 1'b0, 10);
    rst_at = 16;
`else
    run_op("nodiv_div",    2'b10, 32'hFFFF_FFF9, 32'd2, m_hi, m_lo, 0, 1'b0, 1'b0, 0);
    run_op("mult_m2x3_b",  2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, LAT, 1'b1, 1'b0, 0);
    run_op("nodiv_divu",   2'b11, 32'd100, 32'd7, m_hi, m_lo, 0, 1'b0, 1'b0, 0);
    run_op("mult_disturbed", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, LAT, 1'b1, 1'b0, 1);
    rst_at = 2;
`endif
    move("mthi_idle", 1'b1, 1'b0, 32'd5);

    // Reset in the middle of an operation: nothing may reach HI/LO and no done may follow.
    @(negedge clk);
`ifdef MDU_DIV_EN
    op = 2'b10;
`else
    op = 2'b00;
`endif
    a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < rst_at) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    check_hilo("midrst", 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("multu_after_rst", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, LAT, 1'b1, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
